// File: rtl/tuner_pkg.sv
// Shared widths, defaults and state encoding for the tuning measurement sequencer.
package tuner_pkg;
  localparam int SAMPLE_W            = 24;
  localparam int FREQ_W              = 16;
  localparam int HYST_DEFAULT        = 4096;
  localparam int ERROR_RANGE_DEFAULT = 50;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_PLAY    = 3'd1;
  localparam state_t ST_LISTEN  = 3'd2;
  localparam state_t ST_COMPARE = 3'd3;
  localparam state_t ST_DONE    = 3'd4;
endpackage

// File: rtl/tuner_crossing_counter.sv
// Hysteresis-qualified rising zero-crossing counter; a crossing needs a dip below
// -HYST followed by a rise above +HYST. Count saturates at all-ones.
module crossing_counter
  import tuner_pkg::*;
#(
  parameter int HYST = HYST_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [FREQ_W-1:0]   count
);
  localparam logic signed [SAMPLE_W-1:0] THR_HI = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] THR_LO = -THR_HI;

  logic armed;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      armed <= 1'b0;
      count <= '0;
    end else if (en) begin
      if (sample < THR_LO) begin
        armed <= 1'b1;
      end else if (sample > THR_HI && armed) begin
        armed <= 1'b0;
        if (count != {FREQ_W{1'b1}}) count <= count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tuner_sequencer.sv
// One-shot tuning measurement: optional tone playback, fixed capture window,
// crossing count scaled to Hz and compared against the expected note.
//   state   | meaning
//   IDLE    | waiting for start, results held
//   PLAY    | tone on, writing PLAY_SAMPLES DAC samples
//   LISTEN  | reading WINDOW_SAMPLES ADC samples, counting crossings
//   COMPARE | latch frequency, match, greater
//   DONE    | results valid, start re-arms
module tuner_sequencer
  import tuner_pkg::*;
#(
  parameter int PLAY_SAMPLES   = 48000,
  parameter int WINDOW_SAMPLES = 48000,
  parameter int SCALE          = 1,
  parameter int HYST           = HYST_DEFAULT,
  parameter int ERROR_RANGE    = ERROR_RANGE_DEFAULT
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mode_play,
  input  logic                       read_ready,
  input  logic                       write_ready,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic        [FREQ_W-1:0]   expected_freq,
  output logic                       read,
  output logic                       write,
  output logic                       tone_en,
  output logic                       busy,
  output logic                       result_valid,
  output logic        [FREQ_W-1:0]   frequency,
  output logic                       match,
  output logic                       greater
);
  state_t              state;
  logic [31:0]         sample_cnt;
  logic [FREQ_W-1:0]   cross_cnt;
  logic                start_accept;
  logic                count_en;
  logic [31:0]         product;
  logic [FREQ_W-1:0]   freq_next;
  logic [FREQ_W:0]     diff_up;
  logic [FREQ_W:0]     diff_dn;
  logic [FREQ_W:0]     abs_diff;
  logic                greater_next;
  logic                match_next;

  assign read         = (state == ST_LISTEN) && read_ready;
  assign write        = (state == ST_PLAY) && write_ready;
  assign tone_en      = (state == ST_PLAY);
  assign busy         = (state == ST_PLAY) || (state == ST_LISTEN) || (state == ST_COMPARE);
  assign result_valid = (state == ST_DONE);

  assign start_accept = ((state == ST_IDLE) || (state == ST_DONE)) && start && !abort;
  assign count_en     = read && !abort;

  crossing_counter #(.HYST(HYST)) u_crossing (
    .clk    (CLOCK_50),
    .reset  (reset),
    .clear  (start_accept),
    .en     (count_en),
    .sample (sample_in),
    .count  (cross_cnt)
  );

  // Saturate the scaled count; differences carry a borrow bit to give the ordering.
  assign product      = 32'(cross_cnt) * 32'(SCALE);
  assign freq_next    = (product > 32'h0000_FFFF) ? {FREQ_W{1'b1}} : product[FREQ_W-1:0];
  assign diff_up      = {1'b0, freq_next} - {1'b0, expected_freq};
  assign diff_dn      = {1'b0, expected_freq} - {1'b0, freq_next};
  assign greater_next = !diff_up[FREQ_W];
  assign abs_diff     = greater_next ? diff_up : diff_dn;
  assign match_next   = (abs_diff <= (FREQ_W+1)'(ERROR_RANGE));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      frequency  <= '0;
      match      <= 1'b0;
      greater    <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= mode_play ? ST_PLAY : ST_LISTEN;
            sample_cnt <= '0;
          end
        end
        ST_PLAY: begin
          if (write_ready) begin
            if (sample_cnt == 32'(PLAY_SAMPLES - 1)) begin
              state      <= ST_LISTEN;
              sample_cnt <= '0;
            end else begin
              sample_cnt <= sample_cnt + 32'd1;
            end
          end
        end
        ST_LISTEN: begin
          if (read_ready) begin
            if (sample_cnt == 32'(WINDOW_SAMPLES - 1)) begin
              state      <= ST_COMPARE;
              sample_cnt <= '0;
            end else begin
              sample_cnt <= sample_cnt + 32'd1;
            end
          end
        end
        ST_COMPARE: begin
          frequency <= freq_next;
          match     <= match_next;
          greater   <= greater_next;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tuner_sequencer.sv
// Directed bench for tuner_sequencer: square/noise windows, play phase, abort,
// start while busy and reset, with hand-computed frequency/match/greater.
module tb_tuner_sequencer;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               mode_play = 1'b0;
  logic               read_ready = 1'b0;
  logic               write_ready = 1'b0;
  logic signed [23:0] sample_in = '0;
  logic [15:0]        expected_freq = '0;
  logic               read, write, tone_en, busy, result_valid, match, greater;
  logic [15:0]        frequency;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int tone_bad = 0;
  int rd_base, wr_base, rd_snap;

  tuner_sequencer #(
    .PLAY_SAMPLES(64), .WINDOW_SAMPLES(480), .SCALE(100), .HYST(4096), .ERROR_RANGE(50)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .abort(abort), .mode_play(mode_play),
    .read_ready(read_ready), .write_ready(write_ready), .sample_in(sample_in),
    .expected_freq(expected_freq), .read(read), .write(write), .tone_en(tone_en),
    .busy(busy), .result_valid(result_valid), .frequency(frequency), .match(match),
    .greater(greater)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read) rd_cnt <= rd_cnt + 1;
    if (write) wr_cnt <= wr_cnt + 1;
    if (write && !tone_en) tone_bad <= tone_bad + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [23:0] sval(input int kind, input int i);
    int v;
    if (kind == 0) v = (((i / 4) % 2) == 0) ? -100000 : 100000;
    else           v = ((i % 8) * 250) - 1000;
    return 24'(v);
  endfunction

  task automatic start_meas(input logic mp);
    mode_play = mp;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // n accepted samples, one every gap cycles; returns just after the last accepting edge
  task automatic run_listen(input int n, input int gap, input int kind, input int base);
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < gap; g++) begin
        read_ready = 1'b0;
        step();
      end
      read_ready = 1'b1;
      sample_in  = sval(kind, base + i);
      step();
    end
    read_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int f, input logic m, input logic g);
    check({tag, "_compare_busy"}, busy, 1);
    check({tag, "_compare_rv"}, result_valid, 0);
    step();
    check({tag, "_rv"}, result_valid, 1);
    check({tag, "_freq"}, frequency, f);
    check({tag, "_match"}, match, m);
    check({tag, "_greater"}, greater, g);
  endtask

  initial begin
    // reset with start held high
    start = 1'b1;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_rw_tone", {read, write, tone_en}, 0);
    check("rst_freq", frequency, 0);
    check("rst_mg", {match, greater}, 0);
    reset = 1'b0;
    start = 1'b0;
    step();

    // square wave, read_ready 1 in 4: 60 crossings -> 6000 Hz
    expected_freq = 16'd6030;
    start_meas(1'b0);
    check("sq_tone_off", tone_en, 0);
    rd_base = rd_cnt;
    run_listen(480, 4, 0, 0);
    check("sq_reads", rd_cnt - rd_base, 480);
    check_result("sq", 6000, 1'b1, 1'b0);

    // sub-hysteresis triangle: no crossings
    expected_freq = 16'd440;
    start_meas(1'b0);
    run_listen(480, 1, 1, 0);
    check_result("noise", 0, 1'b0, 1'b0);

    // play then listen, write_ready 1 in 3
    expected_freq = 16'd5900;
    wr_base = wr_cnt;
    rd_snap = rd_cnt;
    start_meas(1'b1);
    check("play_tone_on", tone_en, 1);
    for (int c = 0; c < 1000 && (wr_cnt - wr_base) < 64; c++) begin
      write_ready = (c % 3 == 0);
      step();
    end
    write_ready = 1'b1;
    check("play_writes", wr_cnt - wr_base, 64);
    check("play_no_early_read", rd_cnt - rd_snap, 0);
    check("play_tone_after", tone_en, 0);
    check("play_busy_after", busy, 1);
    step();
    step();
    check("play_writes_stop", wr_cnt - wr_base, 64);
    check("play_tone_bad", tone_bad, 0);
    write_ready = 1'b0;
    run_listen(480, 1, 0, 0);
    check_result("play", 6000, 1'b0, 1'b1);

    // abort mid-window: results held, read drops
    expected_freq = 16'd6000;
    start_meas(1'b0);
    run_listen(200, 1, 0, 0);
    abort = 1'b1;
    read_ready = 1'b1;
    step();
    abort = 1'b0;
    check("abort_read", read, 0);
    check("abort_busy", busy, 0);
    check("abort_rv", result_valid, 0);
    check("abort_freq_held", frequency, 6000);
    check("abort_mg_held", {match, greater}, 2'b01);
    read_ready = 1'b0;
    step();
    rd_base = rd_cnt;
    start_meas(1'b0);
    run_listen(480, 1, 0, 0);
    check("abort_new_reads", rd_cnt - rd_base, 480);
    check_result("after_abort", 6000, 1'b1, 1'b1);

    // start while busy is ignored
    expected_freq = 16'd6030;
    start_meas(1'b0);
    run_listen(100, 2, 0, 0);
    start = 1'b1;
    mode_play = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_busy", busy, 1);
    check("busy_start_no_play", tone_en, 0);
    run_listen(380, 2, 0, 100);
    check_result("busy_start", 6000, 1'b1, 1'b0);

    // abort and start together from DONE: abort wins
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_rv", result_valid, 0);

    // reset mid-measurement
    start_meas(1'b0);
    run_listen(50, 1, 0, 0);
    reset = 1'b1;
    read_ready = 1'b1;
    step();
    check("midrst_read", read, 0);
    check("midrst_busy_rv", {busy, result_valid}, 0);
    check("midrst_freq", frequency, 0);
    check("midrst_mg", {match, greater}, 0);
    reset = 1'b0;
    read_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
